// File: rtl/seven_seg_scan_decoder.sv
// seven_seg_scan_decoder: demultiplexes a scanned active-low 7-seg bus into per-digit raw/hex registers.
// Define SCAN_ERR_COUNT_EN to add a saturating err_count output.
module seven_seg_scan_decoder #(
  parameter int NUM_DIGITS = 3,
  parameter int SETTLE_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   enables,
  input  logic [7:0]              segments,
  output logic [8*NUM_DIGITS-1:0] digit_raw,
  output logic [4*NUM_DIGITS-1:0] digit_hex,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    scan_error,
  output logic                    stale
`ifdef SCAN_ERR_COUNT_EN
  , output logic [7:0]            err_count
`endif
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {WAIT, SETTLE, HOLD} state_t;
  state_t state_q, state_d;
  logic [NUM_DIGITS-1:0] s_en_q, seen_q, seen_set;
  logic [7:0] s_seg_q, cs_q, cs_d;
  logic [IW-1:0] ci_q, ci_d, idx;
  logic [3:0] cnt_q, cnt_d;
  logic [TW-1:0] tmo_q;
  logic [8*NUM_DIGITS-1:0] raw_q;
  logic [4*NUM_DIGITS-1:0] hex_q;
  logic [NUM_DIGITS-1:0] valid_q;
  logic frame_q, scan_err_q, stale_q;
  logic any_low, multi_low, one_low, same, ld, cap;

  // {valid, nibble}; dp is not part of the pattern
  function automatic logic [4:0] decode(input logic [6:0] s);
    case (s)
      7'h40: decode = 5'h10;
      7'h79: decode = 5'h11;
      7'h24: decode = 5'h12;
      7'h30: decode = 5'h13;
      7'h19: decode = 5'h14;
      7'h12: decode = 5'h15;
      7'h02: decode = 5'h16;
      7'h78: decode = 5'h17;
      7'h00: decode = 5'h18;
      7'h10: decode = 5'h19;
      7'h08: decode = 5'h1A;
      7'h03: decode = 5'h1B;
      7'h46: decode = 5'h1C;
      7'h21: decode = 5'h1D;
      7'h06: decode = 5'h1E;
      7'h0E: decode = 5'h1F;
      default: decode = 5'h00;
    endcase
  endfunction

  always_comb begin
    any_low = 1'b0;
    multi_low = 1'b0;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!s_en_q[i]) begin
        multi_low = multi_low | any_low;
        any_low = 1'b1;
        idx = IW'(i);
      end
    end
  end

  assign one_low = any_low & ~multi_low;
  assign same = one_low && idx == ci_q && s_seg_q == cs_q;

  // ld reloads the candidate; with SETTLE_CYCLES=1 a reload is itself a capture
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    ci_d = ci_q;
    cs_d = cs_q;
    cap = 1'b0;
    ld = 1'b0;
    case (state_q)
      WAIT: ld = one_low;
      SETTLE: begin
        if (!one_low) state_d = WAIT;
        else if (same) begin
          cnt_d = cnt_q + 4'd1;
          cap = cnt_d == 4'(SETTLE_CYCLES);
          state_d = cap ? HOLD : SETTLE;
        end else ld = 1'b1;
      end
      default: begin
        if (!one_low) state_d = WAIT;
        else ld = !same;
      end
    endcase
    if (ld) begin
      ci_d = idx;
      cs_d = s_seg_q;
      cnt_d = 4'd1;
      cap = SETTLE_CYCLES == 1;
      state_d = SETTLE_CYCLES == 1 ? HOLD : SETTLE;
    end
  end

  always_comb begin
    seen_set = seen_q;
    for (int i = 0; i < NUM_DIGITS; i++) if (cap && ci_d == IW'(i)) seen_set[i] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_en_q <= '1;
      s_seg_q <= 8'hFF;
      state_q <= WAIT;
      cnt_q <= '0;
      ci_q <= '0;
      cs_q <= 8'hFF;
      seen_q <= '0;
      tmo_q <= '0;
      raw_q <= '1;
      hex_q <= '0;
      valid_q <= '0;
      frame_q <= 1'b0;
      scan_err_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      s_en_q <= enables;
      s_seg_q <= segments;
      state_q <= state_d;
      cnt_q <= cnt_d;
      ci_q <= ci_d;
      cs_q <= cs_d;
      scan_err_q <= multi_low;
      frame_q <= cap & (&seen_set);
      seen_q <= &seen_set ? '0 : seen_set;
      if (cap) begin
        tmo_q <= '0;
        stale_q <= 1'b0;
      end else if (tmo_q != TW'(TIMEOUT_CYCLES)) begin
        tmo_q <= tmo_q + 1'b1;
        stale_q <= tmo_q == TW'(TIMEOUT_CYCLES - 1);
      end
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (cap && ci_d == IW'(k)) begin
          raw_q[8*k +: 8] <= cs_d;
          {valid_q[k], hex_q[4*k +: 4]} <= decode(cs_d[6:0]);
        end
      end
    end
  end

`ifdef SCAN_ERR_COUNT_EN
  logic [7:0] err_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= '0;
    else if (scan_err_q && err_q != 8'hFF) err_q <= err_q + 8'd1;
  end
  assign err_count = err_q;
`endif

  assign digit_raw = raw_q;
  assign digit_hex = hex_q;
  assign digit_valid = valid_q;
  assign frame_done = frame_q;
  assign scan_error = scan_err_q;
  assign stale = stale_q;
endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb_seven_seg_scan_decoder: directed checks of a SETTLE_CYCLES=1 and a SETTLE_CYCLES=3 instance on a shared bus.
module tb_seven_seg_scan_decoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] en = 3'b111;
  logic [7:0] seg = 8'hFF;
  logic [23:0] r1, r3;
  logic [11:0] h1, h3;
  logic [2:0] v1, v3;
  logic f1, f3, e1, e3, s1, s3;
  int checks = 0;
  int failures = 0;
  int n1, n3;

  typedef struct {
    logic [2:0] en;
    logic [7:0] seg;
    int k;
    logic [3:0] hex;
    logic vld;
  } vec_t;
  vec_t tbl[20];

  always #5 clk = ~clk;

`ifdef SCAN_ERR_COUNT_EN
  logic [7:0] ec1, ec3;
`endif

  seven_seg_scan_decoder #(.NUM_DIGITS(3), .SETTLE_CYCLES(1), .TIMEOUT_CYCLES(1024)) d1 (
    .clk(clk), .rst_n(rst_n), .enables(en), .segments(seg),
    .digit_raw(r1), .digit_hex(h1), .digit_valid(v1),
    .frame_done(f1), .scan_error(e1), .stale(s1)
`ifdef SCAN_ERR_COUNT_EN
    , .err_count(ec1)
`endif
  );

  seven_seg_scan_decoder #(.NUM_DIGITS(3), .SETTLE_CYCLES(3), .TIMEOUT_CYCLES(1024)) d3 (
    .clk(clk), .rst_n(rst_n), .enables(en), .segments(seg),
    .digit_raw(r3), .digit_hex(h3), .digit_valid(v3),
    .frame_done(f3), .scan_error(e3), .stale(s3)
`ifdef SCAN_ERR_COUNT_EN
    , .err_count(ec3)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] e, input logic [7:0] s, input int n);
    en = e;
    seg = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    tbl[0]  = '{3'b110, 8'hC0, 0, 4'h0, 1'b1};
    tbl[1]  = '{3'b101, 8'hF9, 1, 4'h1, 1'b1};
    tbl[2]  = '{3'b011, 8'hA4, 2, 4'h2, 1'b1};
    tbl[3]  = '{3'b110, 8'hB0, 0, 4'h3, 1'b1};
    tbl[4]  = '{3'b101, 8'h99, 1, 4'h4, 1'b1};
    tbl[5]  = '{3'b011, 8'h92, 2, 4'h5, 1'b1};
    tbl[6]  = '{3'b110, 8'h82, 0, 4'h6, 1'b1};
    tbl[7]  = '{3'b101, 8'hF8, 1, 4'h7, 1'b1};
    tbl[8]  = '{3'b011, 8'h80, 2, 4'h8, 1'b1};
    tbl[9]  = '{3'b110, 8'h90, 0, 4'h9, 1'b1};
    tbl[10] = '{3'b101, 8'h88, 1, 4'hA, 1'b1};
    tbl[11] = '{3'b011, 8'h83, 2, 4'hB, 1'b1};
    tbl[12] = '{3'b110, 8'hC6, 0, 4'hC, 1'b1};
    tbl[13] = '{3'b101, 8'hA1, 1, 4'hD, 1'b1};
    tbl[14] = '{3'b011, 8'h86, 2, 4'hE, 1'b1};
    tbl[15] = '{3'b110, 8'h8E, 0, 4'hF, 1'b1};
    tbl[16] = '{3'b101, 8'hFF, 1, 4'h0, 1'b0};
    tbl[17] = '{3'b011, 8'h7F, 2, 4'h0, 1'b0};
    tbl[18] = '{3'b110, 8'h40, 0, 4'h0, 1'b1};
    tbl[19] = '{3'b101, 8'h49, 1, 4'h0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_raw", {8'h0, r1}, {8'h0, 24'hFFFFFF});
    chk("reset_hex", {20'h0, h1}, 32'h0);
    chk("reset_valid", {29'h0, v1}, 32'h0);
    chk("reset_flags", {29'h0, f1, e1, s1}, 32'h0);
    rst_n = 1'b1;

    for (int i = 1; i <= 1100; i++) begin
      @(negedge clk);
      if (i == 1023) chk("stale_before", {31'h0, s1}, 32'h0);
      if (i == 1024) chk("stale_at", {31'h0, s1}, 32'h1);
    end
    chk("idle_raw", {8'h0, r1}, {8'h0, 24'hFFFFFF});
    chk("idle_valid_fd_se", {27'h0, v1, f1, e1}, 32'h0);

    for (int c = 0; c < 15; c++) begin
      if (c >= 2) chk("rot_frame_done", {31'h0, f1}, {31'h0, (c == 4 || c == 7 || c == 10 || c == 13)});
      if (c >= 2) chk("rot_stale", {31'h0, s1}, 32'h0);
      case (c % 3)
        0: begin en = 3'b110; seg = 8'hC0; end
        1: begin en = 3'b101; seg = 8'hF9; end
        default: begin en = 3'b011; seg = 8'hA4; end
      endcase
      if (c >= 12) begin en = 3'b111; seg = 8'hFF; end
      @(negedge clk);
    end
    chk("rot_hex", {20'h0, h1}, 32'h210);
    chk("rot_valid", {29'h0, v1}, 32'h7);
    chk("rot_raw", {8'h0, r1}, 32'hA4F9C0);

    for (int c = 0; c < 6; c++) begin
      if (c >= 1) chk("illegal_scan_error", {31'h0, e1}, {31'h0, c == 3});
      if (c == 0) begin en = 3'b110; seg = 8'hC0; end
      else if (c == 1) begin en = 3'b100; seg = 8'h00; end
      else begin en = 3'b111; seg = 8'hFF; end
      @(negedge clk);
    end
    chk("illegal_raw", {8'h0, r1}, 32'hA4F9C0);
    chk("illegal_hex", {20'h0, h1}, 32'h210);

    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c == 5) chk("settle_no_capture", {23'h0, v3[0], r3[7:0]}, 32'h0FF);
      if (c == 6) chk("settle_capture", {19'h0, v3[0], h3[3:0], r3[7:0]}, 32'h1592);
      en = c < 5 ? 3'b110 : 3'b111;
      seg = c < 2 ? 8'h99 : (c < 5 ? 8'h92 : 8'hFF);
      @(negedge clk);
    end

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].seg, 3);
      chk("dec_raw", {24'h0, r1[8*tbl[i].k +: 8]}, {24'h0, tbl[i].seg});
      chk("dec_hex", {28'h0, h1[4*tbl[i].k +: 4]}, {28'h0, tbl[i].hex});
      chk("dec_valid", {31'h0, v1[tbl[i].k]}, {31'h0, tbl[i].vld});
    end

    drive(3'b110, 8'hC0, 4);
    drive(3'b101, 8'hF9, 4);
    drive(3'b011, 8'hA4, 2);
    rst_n = 1'b0;
    #1;
    chk("midreset_raw1", {8'h0, r1}, {8'h0, 24'hFFFFFF});
    chk("midreset_raw3", {8'h0, r3}, {8'h0, 24'hFFFFFF});
    chk("midreset_hv", {14'h0, h1, v1, v3}, 32'h0);
    chk("midreset_flags", {26'h0, f1, e1, s1, f3, e3, s3}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    n1 = 0;
    n3 = 0;
    for (int c = 0; c < 19; c++) begin
      n1 += int'(f1);
      n3 += int'(f3);
      if (c == 8) chk("midreset_no_early_frame", n1 + n3, 0);
      if (c < 4) begin en = 3'b011; seg = 8'hA4; end
      else if (c < 8) begin en = 3'b110; seg = 8'hC0; end
      else if (c < 12) begin en = 3'b101; seg = 8'hF9; end
      else begin en = 3'b111; seg = 8'hFF; end
      @(negedge clk);
    end
    chk("midreset_frames1", n1, 1);
    chk("midreset_frames3", n3, 1);
    chk("midreset_hex3", {20'h0, h3}, 32'h210);

`ifdef SCAN_ERR_COUNT_EN
    drive(3'b000, 8'h00, 300);
    drive(3'b111, 8'hFF, 3);
    chk("err_count_sat", {24'h0, ec1}, 32'hFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
Receive-side counterpart of the multiplexed 7-segment driver. Samples the time-multiplexed, active-low enables/segments bus and demultiplexes it back into per-digit segment registers. Decodes each digit to a hex nibble and flags frame completion, illegal scans and scan stall. Used in self-check loops and as a monitor on the display bus.

Parameters:
NUM_DIGITS, 3, number of digit enables on the bus
SETTLE_CYCLES, 1, consecutive identical samples (same digit, same segments) required before capture; legal range 1-15
TIMEOUT_CYCLES, 1024, cycles without a capture before stale asserts; legal range >= 2

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enables  in  NUM_DIGITS  digit enables, active-low, one-hot-low when driving
segments  in  8  active-low; bit0=a … bit6=g, bit7=dp
digit_raw  out  8*NUM_DIGITS  captured segment byte per digit; digit k at [8k+7:8k]
digit_hex  out  4*NUM_DIGITS  decoded nibble per digit; digit k at [4k+3:4k]
digit_valid  out  NUM_DIGITS  1 = digit k's captured pattern matched the hex table
frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse
scan_error  out  1  one-cycle pulse per sample with more than one enable low
stale  out  1  high once TIMEOUT_CYCLES elapse without a capture; cleared on the next capture

Behaviour:
- Reset values: digit_raw all 1s (blank), digit_hex 0, digit_valid 0, frame_done 0, scan_error 0, stale 0. Seen-mask 0, settle counter 0, timeout counter 0, FSM in WAIT.
- Input stage: enables and segments are registered every clk into s_en and s_seg. All further logic uses only the registered values.
- Classification of s_en:
  - Exactly one bit low → index k.
  - All bits high → idle.
  - Otherwise → illegal; pulse scan_error on the next cycle.
- FSM:
  - WAIT: on index k go to SETTLE with cnt=1, latching k and s_seg as the candidate.
  - SETTLE: if index and s_seg equal the candidate, increment cnt. Otherwise reload the candidate with cnt=1, or go to WAIT if idle or illegal. When cnt reaches SETTLE_CYCLES, capture and go to HOLD.
  - HOLD: stay while index and s_seg are unchanged, with no recapture. On a change go to SETTLE with the new candidate; on idle or illegal go to WAIT.
  - SETTLE_CYCLES=1: capture happens on the same edge the candidate is first latched, i.e. WAIT→HOLD directly.
- Latency: with SETTLE_CYCLES=1, a stable value presented before edge N is registered at N and visible on the digit outputs after edge N+1. Each extra settle cycle adds one edge.
- Capture of digit k, all on the same edge:
  - digit_raw[k] ← candidate.
  - digit_hex[k] and digit_valid[k] ← decode(candidate).
  - Set seen[k]; clear the timeout counter and stale.
- Decode ignores dp (bit7 treated as 1). Patterns in bits[6:0] map to hex:
  0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
  Any other pattern → hex 0, valid 0.
- Frame: if a capture makes seen all 1s, pulse frame_done on that edge and clear seen to 0. The capture that completes the frame is not carried into the next frame. Recapturing an already-seen digit does not pulse.
- Timeout: the counter increments every cycle without a capture and saturates at TIMEOUT_CYCLES. stale is set on the cycle it reaches TIMEOUT_CYCLES.
- Simultaneous events: if a capture and the timeout threshold fall on the same cycle, the capture wins and stale stays 0.
- Mid-operation reset: all state returns to reset values immediately. Partial frames are discarded.

Optional Feature:
SCAN_ERR_COUNT_EN.
- Defined: adds output port err_count (8 bits), reset 0. It increments on each scan_error pulse and saturates at 255.
- Undefined: no port and no counter; all other behaviour is identical.

Test Plan:
- Reset then idle (enables=3'b111) for 1100 cycles → all outputs at reset values; stale=1 from cycle 1024 after reset release.
- Drive the driver pattern 110/0xC0, 101/0xF9, 011/0xA4, one cycle each, repeating → digit_hex={2,1,0}, digit_valid=3'b111, frame_done pulses once per 3-cycle rotation, stale stays 0.
- SETTLE_CYCLES=3: digit0 holds 0x99 for 2 cycles, then 0x92 for 3 cycles → no capture of 0x99; digit0 captures 0x92 (hex 5).
- enables=3'b100 for one cycle mid-scan → scan_error pulses once; FSM returns to WAIT; no digit changes.
- Digit1 driven with 0xFF (blank) and digit2 with 0x7F (dp only) → digit_raw updated; digit_valid[1]=0, digit_valid[2]=0, hex 0. 0x40 with dp low → hex 0, valid 1.
- rst_n low during SETTLE after a partial frame → outputs return to reset values; the next full rotation produces exactly one frame_done. With SCAN_ERR_COUNT_EN: 300 illegal samples → err_count=255.
